// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor:
// poses, sheet origins, palette and fixed colours.
package sprite_pkg;

  typedef enum logic [2:0] {
    POSE_IDLE,
    POSE_MOVE,
    POSE_ATTACK,
    POSE_SHIELD,
    POSE_DEAD
  } pose_t;

  localparam logic [8:0] ROW_PR   = 9'd0;
  localparam logic [8:0] ROW_PL   = 9'd60;
  localparam logic [8:0] ROW_ER   = 9'd120;
  localparam logic [8:0] ROW_EL   = 9'd180;
  localparam logic [8:0] ROW_DEAD = 9'd240;

  localparam logic [8:0] COL_IDLE   = 9'd0;
  localparam logic [8:0] COL_MOVE   = 9'd40;
  localparam logic [8:0] COL_STEP   = 9'd40;
  localparam logic [8:0] COL_ATTACK = 9'd160;
  localparam logic [8:0] COL_SHIELD = 9'd200;
  localparam logic [8:0] COL_DEAD   = 9'd40;

  localparam logic [23:0] PLAT_RGB = 24'hff6347;
  localparam logic [7:0]  BG_R     = 8'h00;
  localparam logic [7:0]  BG_G     = 8'hbf;
  localparam logic [7:0]  BG_B     = 8'hff;

  function automatic logic [23:0] pal_rgb(
    input logic [4:0] idx
  );
    logic [23:0] c;
    case (idx)
      5'd0:    c = 24'hffffff;
      5'd1:    c = 24'h000000;
      5'd2:    c = 24'h323232;
      5'd3:    c = 24'h888888;
      5'd4:    c = 24'h7b100c;
      5'd5:    c = 24'hff0000;
      5'd6:    c = 24'hc58564;
      5'd7:    c = 24'h4b1400;
      5'd8:    c = 24'hbb8044;
      5'd9:    c = 24'hc58f5c;
      5'd10:   c = 24'hc99869;
      5'd11:   c = 24'hca6225;
      5'd12:   c = 24'hc25820;
      5'd13:   c = 24'hf79534;
      5'd14:   c = 24'hf9953b;
      5'd15:   c = 24'hfb9533;
      5'd16:   c = 24'hfd9737;
      5'd17:   c = 24'hf5cea1;
      5'd18:   c = 24'h80be1f;
      5'd19:   c = 24'h93db24;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sprite_compositor_hit.sv
// Box hit test for one sprite; signed compare
// so boxes clipped at the left/top edge still hit.
module sprite_hit_unit #(
  parameter int HALF_W = 20,
  parameter int HALF_H = 30,
  parameter int CW     = 6,
  parameter int RW     = 6
) (
  input  logic [9:0]    x_i,
  input  logic [9:0]    y_i,
  input  logic          en_i,
  input  logic [9:0]    px_i,
  input  logic [9:0]    py_i,
  output logic          hit_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o
);

  logic signed [11:0] px, py;
  logic signed [11:0] lo_x, hi_x;
  logic signed [11:0] lo_y, hi_y;

  assign px   = $signed({2'b00, px_i});
  assign py   = $signed({2'b00, py_i});
  assign lo_x = $signed({2'b00, x_i})
              - $signed(12'(HALF_W));
  assign hi_x = $signed({2'b00, x_i})
              + $signed(12'(HALF_W - 1));
  assign lo_y = $signed({2'b00, y_i})
              - $signed(12'(HALF_H));
  assign hi_y = $signed({2'b00, y_i})
              + $signed(12'(HALF_H - 1));

  assign hit_o = en_i
              && (px >= lo_x) && (px <= hi_x)
              && (py >= lo_y) && (py <= hi_y);
  assign col_o = CW'(px - lo_x);
  assign row_o = RW'(py - lo_y);

endmodule

// File: rtl/sprite_compositor.sv
// Pipelined sprite compositor: per-frame shadows, ROM
// address generation, palette select, overlap mask.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 5,
  parameter int HALF_W      = 20,
  parameter int HALF_H      = 30,
  parameter int SHEET_W     = 240,
  parameter int PAL_DEPTH   = 20,
  parameter int FRAME_DIV   = 4,
  parameter int ADDR_W      = 19
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [NUM_SPRITES-1:0][9:0] sprite_x,
  input  logic [NUM_SPRITES-1:0][9:0] sprite_y,
  input  logic [NUM_SPRITES-1:0]      sprite_en,
  input  logic [NUM_SPRITES-1:0]      sprite_dir,
  input  pose_t [NUM_SPRITES-1:0]     sprite_pose,
  input  logic                        is_platform,
  output logic [ADDR_W-1:0]           read_address,
  input  logic [4:0]                  data_Out,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        rgb_valid,
  output logic [NUM_SPRITES-1:0]      overlap_mask
);

  localparam int CW   = $clog2(2 * HALF_W);
  localparam int RW   = $clog2(2 * HALF_H);
  localparam int FC_W = (FRAME_DIV > 1)
                      ? $clog2(FRAME_DIV) : 1;

  logic [NUM_SPRITES-1:0][9:0] sx_q, sy_q;
  logic [NUM_SPRITES-1:0]      sen_q, sdir_q;
  pose_t [NUM_SPRITES-1:0]     spose_q;
  logic [FC_W-1:0]             fcnt_q;
  logic                        phase_q;

  logic [NUM_SPRITES-1:0]         hit;
  logic [NUM_SPRITES-1:0][CW-1:0] col;
  logic [NUM_SPRITES-1:0][RW-1:0] row;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_unit #(
      .HALF_W(HALF_W),
      .HALF_H(HALF_H),
      .CW    (CW),
      .RW    (RW)
    ) u_hit (
      .x_i  (sx_q[g]),
      .y_i  (sy_q[g]),
      .en_i (sen_q[g]),
      .px_i (DrawX),
      .py_i (DrawY),
      .hit_o(hit[g]),
      .col_o(col[g]),
      .row_o(row[g])
    );
  end

  logic          win_hit, win_player, win_dir;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  pose_t         win_pose;

  // Walk from the top index down so the lowest hit wins.
  always_comb begin
    win_hit    = 1'b0;
    win_player = 1'b0;
    win_dir    = 1'b0;
    win_col    = '0;
    win_row    = '0;
    win_pose   = POSE_IDLE;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_hit    = 1'b1;
        win_player = (i == 0);
        win_dir    = sdir_q[i];
        win_col    = col[i];
        win_row    = row[i];
        win_pose   = spose_q[i];
      end
    end
  end

  logic [8:0]        rowbase, colbase;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    if (win_pose == POSE_DEAD) rowbase = ROW_DEAD;
    else if (win_player)
      rowbase = win_dir ? ROW_PR : ROW_PL;
    else
      rowbase = win_dir ? ROW_ER : ROW_EL;
    unique case (win_pose)
      POSE_IDLE:   colbase = COL_IDLE;
      POSE_MOVE:   colbase = phase_q
                           ? COL_MOVE + COL_STEP
                           : COL_MOVE;
      POSE_ATTACK: colbase = COL_ATTACK;
      POSE_SHIELD: colbase = COL_SHIELD;
      POSE_DEAD:   colbase = COL_DEAD;
      default:     colbase = COL_IDLE;
    endcase
    addr_d = (ADDR_W'(rowbase) + ADDR_W'(win_row))
           * ADDR_W'(SHEET_W)
           + ADDR_W'(colbase) + ADDR_W'(win_col);
    if (!(pix_valid && win_hit)) addr_d = '0;
  end

  logic [NUM_SPRITES-1:0] ov, acc_d, acc_q;

  always_comb begin
    ov = '0;
    for (int i = 1; i < NUM_SPRITES; i++)
      ov[i] = pix_valid & hit[0] & hit[i];
    acc_d = frame_start ? ov : (acc_q | ov);
  end

  logic       hit1_q, plat1_q, v1_q;
  logic [6:0] dx1_q;
  logic       hit2_q, plat2_q, v2_q;
  logic [6:0] dx2_q;
  logic [23:0] rgb_d;

  always_comb begin
    rgb_d = '0;
    if (v2_q) begin
      if (plat2_q)
        rgb_d = PLAT_RGB;
      else if (hit2_q && data_Out != 5'd0
               && 32'(data_Out) < PAL_DEPTH)
        rgb_d = pal_rgb(data_Out);
      else
        rgb_d = {BG_R, BG_G, BG_B - {1'b0, dx2_q}};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_q         <= '0;
      sy_q         <= '0;
      sen_q        <= '0;
      sdir_q       <= '0;
      spose_q      <= {NUM_SPRITES{POSE_IDLE}};
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      acc_q        <= '0;
      overlap_mask <= '0;
      read_address <= '0;
      hit1_q       <= 1'b0;
      plat1_q      <= 1'b0;
      dx1_q        <= '0;
      v1_q         <= 1'b0;
      hit2_q       <= 1'b0;
      plat2_q      <= 1'b0;
      dx2_q        <= '0;
      v2_q         <= 1'b0;
      VGA_R        <= '0;
      VGA_G        <= '0;
      VGA_B        <= '0;
      rgb_valid    <= 1'b0;
    end else begin
      if (frame_start) begin
        sx_q         <= sprite_x;
        sy_q         <= sprite_y;
        sen_q        <= sprite_en;
        sdir_q       <= sprite_dir;
        spose_q      <= sprite_pose;
        overlap_mask <= acc_q;
        if (fcnt_q == FC_W'(FRAME_DIV - 1)) begin
          fcnt_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end
      acc_q        <= acc_d;
      read_address <= addr_d;
      hit1_q       <= pix_valid & win_hit;
      plat1_q      <= is_platform;
      dx1_q        <= DrawX[9:3];
      v1_q         <= pix_valid;
      hit2_q       <= hit1_q;
      plat2_q      <= plat1_q;
      dx2_q        <= dx1_q;
      v2_q         <= v1_q;
      {VGA_R, VGA_G, VGA_B} <= rgb_d;
      rgb_valid    <= v2_q;
    end
  end

endmodule
